ram_dp_sync: RTL and testbench

Parametrised synchronous simple-dual-port RAM; successor to the fixed 4096-deep RAM.
- One write port and one read port, registered read data, read-valid flag, write-first collision bypass.
- Hardware clears all words to zero after reset; optional per-word parity.
- Sits behind the existing ram_if-style driver/monitor bench, and is instantiated directly by datapath blocks that need buffering.

---
 rtl/ram_pkg.sv | 9 +
 rtl/ram_dp_array.sv | 19 +
 rtl/ram_dp_sync.sv | 81 ++++++++
 tb/tb_ram_dp_sync.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared state type, default widths and parity helper for the dual-port RAM.
package ram_pkg;
  typedef enum logic {INIT, READY} ram_state_e;
  localparam int RAM_DATA_WIDTH = 8;
  localparam int RAM_ADDR_WIDTH = 12;
  function automatic logic calc_parity(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/ram_dp_array.sv
// ram_dp_array: bare storage, one write port and one registered read port (block-RAM inferable).
module ram_dp_array #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [WIDTH-1:0]      wd,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [WIDTH-1:0]      q
);
  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) q <= mem[ra];
  end
endmodule

// File: rtl/ram_dp_sync.sv
// ram_dp_sync: simple-dual-port RAM with clear-after-reset, write-first bypass and rd_valid.
// Define RAM_PARITY_EN to add one stored even-parity bit per word plus par_inject/parity_err.
module ram_dp_sync
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  input  logic                  read,
`ifdef RAM_PARITY_EN
  input  logic                  par_inject,
  output logic                  parity_err,
`endif
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  busy
);
`ifdef RAM_PARITY_EN
  localparam int W = DATA_WIDTH + 1;
`else
  localparam int W = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH:0] ONE  = 1;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(2**ADDR_WIDTH - 1);
  ram_state_e state, state_nx;
  logic [ADDR_WIDTH:0] init_addr;
  logic [W-1:0] wd, q, byp, rdata;
  logic we, re, hit, clr;
  assign busy = state == INIT;
  assign we = busy | write;
  assign re = ~busy & read;
`ifdef RAM_PARITY_EN
  assign wd = busy ? '0 : {calc_parity(64'(data_in)) ^ par_inject, data_in};
`else
  assign wd = busy ? '0 : data_in;
`endif
  always_comb begin
    state_nx = state;
    if (state == INIT && init_addr == LAST) state_nx = READY;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= INIT;
      init_addr <= '0;
      rd_valid  <= 1'b0;
      hit       <= 1'b0;
      byp       <= '0;
      clr       <= 1'b1;
    end else begin
      state    <= state_nx;
      rd_valid <= re;
      if (busy) init_addr <= init_addr + ONE;
      if (re) begin
        hit <= write && wr_address == rd_address;
        byp <= wd;
        clr <= 1'b0;
      end
    end
  end
  ram_dp_array #(.WIDTH(W), .ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk (clk),
    .we  (we),
    .wa  (busy ? init_addr[ADDR_WIDTH-1:0] : wr_address),
    .wd  (wd),
    .re  (re),
    .ra  (rd_address),
    .q   (q)
  );
  // Array output has no reset; clr masks it until the first read after reset.
  assign rdata = clr ? '0 : hit ? byp : q;
  assign data_out = rdata[DATA_WIDTH-1:0];
`ifdef RAM_PARITY_EN
  assign parity_err = rd_valid & (calc_parity(64'(rdata[DATA_WIDTH-1:0])) ^ rdata[DATA_WIDTH]);
`endif
endmodule

// File: tb/tb_ram_dp_sync.sv
// tb_ram_dp_sync: directed bench with an array-based reference model checked every cycle.
module tb_ram_dp_sync;
  logic clk = 0, resetn = 0, write = 0, read = 0, par_inject = 0;
  logic [7:0] data_in = 0, data_out;
  logic [11:0] wr_address = 0, rd_address = 0;
  logic rd_valid, busy, parity_err;
  int n_chk = 0, n_fail = 0, n;
  bit chk_en = 0;
  always #5 clk = ~clk;

  ram_dp_sync dut (
    .clk        (clk),
    .resetn     (resetn),
    .data_in    (data_in),
    .wr_address (wr_address),
    .write      (write),
    .rd_address (rd_address),
    .read       (read),
`ifdef RAM_PARITY_EN
    .par_inject (par_inject),
    .parity_err (parity_err),
`endif
    .data_out   (data_out),
    .rd_valid   (rd_valid),
    .busy       (busy)
  );
`ifndef RAM_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Reference model: memory contents, remaining clear cycles, last read result.
  logic [7:0] m_mem [4096];
  logic       m_par [4096];
  logic [7:0] e_data;
  logic       e_valid, e_perr;
  int         clr_left;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4096; i++) begin m_mem[i] = 0; m_par[i] = 0; end
      e_data = 0; e_valid = 0; e_perr = 0; clr_left = 4096;
    end else if (clr_left > 0) begin
      clr_left--;
      e_valid = 0;
    end else begin
      e_valid = read;
      if (read) begin
        if (write && wr_address == rd_address) begin
          e_data = data_in;
          e_perr = par_inject;
        end else begin
          e_data = m_mem[rd_address];
          e_perr = (^m_mem[rd_address]) != m_par[rd_address];
        end
      end
      if (write) begin
        m_mem[wr_address] = data_in;
        m_par[wr_address] = (^data_in) ^ par_inject;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    n_chk++;
    if (data_out !== e_data || rd_valid !== e_valid || busy !== (clr_left > 0)) begin
      n_fail++;
      $display("FAIL model t=%0t data_out=%h/%h rd_valid=%b/%b busy=%b/%b", $time,
               data_out, e_data, rd_valid, e_valid, busy, clr_left > 0);
    end
`ifdef RAM_PARITY_EN
    n_chk++;
    if (parity_err !== (e_valid & e_perr)) begin
      n_fail++;
      $display("FAIL model_parity t=%0t parity_err=%b expected=%b", $time, parity_err, e_valid & e_perr);
    end
`endif
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic step(input logic w, input logic [11:0] wa, input logic [7:0] d,
                      input logic r, input logic [11:0] ra, input logic inj);
    write = w; wr_address = wa; data_in = d; read = r; rd_address = ra; par_inject = inj;
    @(negedge clk);
  endtask

  task automatic wait_clear(input string nm);
    n = 0;
    while (busy && n < 5000) begin
      if (n == 10) begin write = 0; read = 0; end
      @(negedge clk);
      n++;
    end
    chk(nm, n, 4096);
  endtask

  initial begin
    @(negedge clk);
    chk_en = 1;
    step(0, 0, 0, 0, 0, 0);
    chk("rst_data", data_out, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_busy", busy, 1);
    chk("rst_perr", parity_err, 0);
    // Release reset with strobes active during the clear
    resetn = 1; write = 1; wr_address = 0; data_in = 8'hFF; read = 1; rd_address = 0;
    wait_clear("clear_cycles");
    step(0, 0, 0, 1, 12'h000, 0);
    chk("rd0_data", data_out, 0);
    chk("rd0_valid", rd_valid, 1);
    step(0, 0, 0, 1, 12'h800, 0);
    chk("rd2048", {rd_valid, data_out}, 9'h100);
    step(0, 0, 0, 1, 12'hFFF, 0);
    chk("rd4095", {rd_valid, data_out}, 9'h100);
    step(1, 12'h123, 8'hA5, 0, 0, 0);
    chk("wr_no_valid", rd_valid, 0);
    step(0, 0, 0, 1, 12'h123, 0);
    chk("rd_a5", data_out, 8'hA5);
    chk("rd_a5_valid", rd_valid, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("hold_data", data_out, 8'hA5);
    chk("hold_valid", rd_valid, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("hold2", {rd_valid, data_out}, 9'h0A5);
    step(1, 12'h010, 8'h11, 0, 0, 0);
    step(1, 12'h010, 8'h3C, 1, 12'h010, 0);
    chk("collision", {rd_valid, data_out}, 9'h13C);
    step(1, 12'h020, 8'h5A, 1, 12'h010, 0);
    chk("after_coll", data_out, 8'h3C);
    step(0, 0, 0, 1, 12'h020, 0);
    chk("b2b_1", {rd_valid, data_out}, 9'h15A);
    step(0, 0, 0, 1, 12'h123, 0);
    chk("b2b_2", {rd_valid, data_out}, 9'h1A5);
    // Reset in the middle of back-to-back reads
    write = 0; read = 1; rd_address = 12'h010;
    #1 resetn = 0;
    #1;
    chk("midrst_data", data_out, 0);
    chk("midrst_valid", rd_valid, 0);
    chk("midrst_busy", busy, 1);
    @(negedge clk);
    @(negedge clk);
    resetn = 1;
    wait_clear("reclear_cycles");
    step(0, 0, 0, 1, 12'h123, 0);
    chk("rd_after_rst", {rd_valid, data_out}, 9'h100);
    step(0, 0, 0, 1, 12'h000, 0);
    chk("init_wr_ignored", {rd_valid, data_out}, 9'h100);
`ifdef RAM_PARITY_EN
    step(1, 12'h055, 8'h07, 0, 0, 1);
    step(0, 0, 0, 1, 12'h055, 0);
    chk("par_inj", {rd_valid, parity_err, data_out}, 10'h307);
    step(1, 12'h055, 8'h07, 0, 0, 0);
    step(0, 0, 0, 1, 12'h055, 0);
    chk("par_ok", {rd_valid, parity_err, data_out}, 10'h107);
    step(1, 12'h066, 8'h81, 1, 12'h066, 1);
    chk("par_bypass", {rd_valid, parity_err, data_out}, 10'h381);
`endif
    step(0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
